// File: rtl/uart_pkg.sv
// Shared UART receive definitions: state encodings, oversample constants, word-length decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int OSM_16  = 16;
    localparam int OSM_13  = 13;
    localparam int HALF_16 = 7;
    localparam int HALF_13 = 6;

    // Word-length select to number of data bits (5..8).
    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'(wls) + 4'd5;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous RX line; resets to the idle (high) level.
// Latency: SYNC_STAGES bclk cycles.
// Backpressure: none; free-running shift chain.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic bclk_in,
    input  logic rstn_in,
    input  logic serial,
    output logic rxd
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the flop chain; reset to 1 so reset never looks like a start bit.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial};
        end
    end

    assign rxd = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deserializer: start validation, 5-8 data bits LSB first, optional parity, one stop bit.
// Latency: strobe on the stop-bit sample edge, SYNC_STAGES + ~9.5 bit times after the falling edge.
// Backpressure: none; rx_valid_out is a one-cycle strobe that the consumer must accept.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       bclk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       serial_in,
    input  logic       osm_sel_in,
    input  logic [1:0] wls_in,
    input  logic       pen_in,
    input  logic       eps_in,
    input  logic       sp_in,
    output logic [7:0] rbr_out,
    output logic       rx_valid_out,
    output logic       pe_out,
    output logic       fe_out,
    output logic       bi_out,
    output logic       busy_out
);

    rx_state_t  state, state_nxt;
    logic [3:0] cyc, cyc_nxt;
    logic [2:0] bitcnt, bitcnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic       par_bit, par_bit_nxt;
    logic       par_err, par_err_nxt;
    logic       rxd;
    logic       load_cfg;

    // Frame configuration, frozen for the duration of a character.
    logic       osm13_q;
    logic [1:0] wls_q;
    logic       pen_q, eps_q, sp_q;

    logic [7:0] rbr_nxt;
    logic       valid_nxt, pe_nxt, fe_nxt, bi_nxt;

    logic [3:0] n_last;
    logic [3:0] half;
    logic [2:0] last_bit;
    logic       par_exp;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .bclk_in (bclk_in),
        .rstn_in (rstn_in),
        .serial  (serial_in),
        .rxd     (rxd)
    );

    assign n_last   = osm13_q ? 4'(OSM_13 - 1) : 4'(OSM_16 - 1);
    assign half     = osm13_q ? 4'(HALF_13) : 4'(HALF_16);
    assign last_bit = 3'(wls_to_bits(wls_q) - 4'd1);
    // Unused MSBs of shift are cleared at frame start, so the XOR covers only real data bits.
    assign par_exp  = sp_q ? !eps_q : (eps_q ? (^shift) : !(^shift));
    assign busy_out = (state != IDLE);

    // State, bit timing, datapath and registered outputs.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state        <= IDLE;
            cyc          <= '0;
            bitcnt       <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            par_err      <= 1'b0;
            osm13_q      <= 1'b0;
            wls_q        <= '0;
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            sp_q         <= 1'b0;
            rbr_out      <= '0;
            rx_valid_out <= 1'b0;
            pe_out       <= 1'b0;
            fe_out       <= 1'b0;
            bi_out       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cyc          <= cyc_nxt;
            bitcnt       <= bitcnt_nxt;
            shift        <= shift_nxt;
            par_bit      <= par_bit_nxt;
            par_err      <= par_err_nxt;
            rbr_out      <= rbr_nxt;
            rx_valid_out <= valid_nxt;
            pe_out       <= pe_nxt;
            fe_out       <= fe_nxt;
            bi_out       <= bi_nxt;
            if (load_cfg) begin
                osm13_q <= osm_sel_in;
                wls_q   <= wls_in;
                pen_q   <= pen_in;
                eps_q   <= eps_in;
                sp_q    <= sp_in;
            end
        end
    end

    // Next-state and datapath decode; disabling the receiver drops any partial frame.
    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc + 4'd1;
        bitcnt_nxt  = bitcnt;
        shift_nxt   = shift;
        par_bit_nxt = par_bit;
        par_err_nxt = par_err;
        load_cfg    = 1'b0;
        rbr_nxt     = rbr_out;
        valid_nxt   = 1'b0;
        pe_nxt      = pe_out;
        fe_nxt      = fe_out;
        bi_nxt      = bi_out;

        if (!enable_in) begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_nxt = '0;
                    if (!rxd) begin
                        state_nxt = START;
                        load_cfg  = 1'b1;
                    end
                end
                START: begin
                    if (cyc == half) begin
                        cyc_nxt = '0;
                        if (rxd) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt   = DATA;
                            bitcnt_nxt  = '0;
                            shift_nxt   = '0;
                            par_bit_nxt = 1'b0;
                            par_err_nxt = 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cyc == n_last) begin
                        cyc_nxt           = '0;
                        shift_nxt[bitcnt] = rxd;
                        if (bitcnt == last_bit) begin
                            state_nxt = pen_q ? PARITY : STOP;
                        end else begin
                            bitcnt_nxt = bitcnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (cyc == n_last) begin
                        cyc_nxt     = '0;
                        par_bit_nxt = rxd;
                        par_err_nxt = (rxd != par_exp);
                        state_nxt   = STOP;
                    end
                end
                STOP: begin
                    if (cyc == n_last) begin
                        cyc_nxt   = '0;
                        rbr_nxt   = shift;
                        pe_nxt    = pen_q & par_err;
                        fe_nxt    = !rxd;
                        bi_nxt    = (shift == 8'h00) && (!pen_q || !par_bit) && !rxd;
                        valid_nxt = 1'b1;
                        state_nxt = rxd ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    cyc_nxt = '0;
                    if (rxd) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frame formats, parity, glitch, break and abort cases.
// Latency: frames are driven at 16 or 13 bclk per bit.
// Backpressure: n/a; strobes are counted by a negedge monitor.
module tb_uart_rx_frame;

    logic       bclk_in = 1'b0;
    logic       rstn_in;
    logic       enable_in;
    logic       serial_in;
    logic       osm_sel_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic [7:0] rbr_out;
    logic       rx_valid_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    int checks     = 0;
    int errors     = 0;
    int cyc_cnt    = 0;
    int strobes    = 0;
    int strobe_cyc = 0;
    int s0;
    int t0;
    int lat;

    uart_rx_frame #(.SYNC_STAGES(2)) dut (
        .bclk_in      (bclk_in),
        .rstn_in      (rstn_in),
        .enable_in    (enable_in),
        .serial_in    (serial_in),
        .osm_sel_in   (osm_sel_in),
        .wls_in       (wls_in),
        .pen_in       (pen_in),
        .eps_in       (eps_in),
        .sp_in        (sp_in),
        .rbr_out      (rbr_out),
        .rx_valid_out (rx_valid_out),
        .pe_out       (pe_out),
        .fe_out       (fe_out),
        .bi_out       (bi_out),
        .busy_out     (busy_out)
    );

    always #5 bclk_in = ~bclk_in;

    always @(posedge bclk_in) cyc_cnt <= cyc_cnt + 1;

    // Count strobes away from the active edge and remember when the last one appeared.
    always @(negedge bclk_in) begin
        if (rx_valid_out === 1'b1) begin
            strobes    = strobes + 1;
            strobe_cyc = cyc_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge bclk_in);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int period);
        serial_in = b;
        cycles(period);
    endtask

    task automatic send_char(input logic [7:0] data, input int nbits, input logic has_par,
                             input logic par, input logic stop, input int period);
        drive_bit(1'b0, period);
        for (int i = 0; i < nbits; i++) drive_bit(data[i], period);
        if (has_par) drive_bit(par, period);
        drive_bit(stop, period);
        serial_in = 1'b1;
    endtask

    initial begin
        rstn_in    = 1'b0;
        enable_in  = 1'b1;
        serial_in  = 1'b1;
        osm_sel_in = 1'b0;
        wls_in     = 2'd3;
        pen_in     = 1'b0;
        eps_in     = 1'b0;
        sp_in      = 1'b0;

        // Reset state.
        cycles(3);
        check("rst_rbr", rbr_out, 8'h00);
        check("rst_flags", {rx_valid_out, pe_out, fe_out, bi_out, busy_out}, 5'b0);
        rstn_in = 1'b1;
        cycles(5);
        check("idle_busy", busy_out, 1'b0);

        // 16x 8N1, 0xA5.
        s0 = strobes;
        t0 = cyc_cnt;
        send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
        cycles(4);
        lat = strobe_cyc - t0;
        check("a5_count", strobes - s0, 1);
        check($sformatf("a5_latency(lat=%0d)", lat), (lat >= 149 && lat <= 155), 1'b1);
        check("a5_rbr", rbr_out, 8'hA5);
        check("a5_flags", {pe_out, fe_out, bi_out, busy_out}, 4'b0);

        // 13x 7E1, 0x35 with good then bad parity.
        osm_sel_in = 1'b1; wls_in = 2'd2; pen_in = 1'b1; eps_in = 1'b1; sp_in = 1'b0;
        s0 = strobes;
        send_char(8'h35, 7, 1'b1, 1'b0, 1'b1, 13);
        cycles(4);
        check("7e1_good_count", strobes - s0, 1);
        check("7e1_good_rbr", rbr_out, 8'h35);
        check("7e1_good_pe", pe_out, 1'b0);
        send_char(8'h35, 7, 1'b1, 1'b1, 1'b1, 13);
        cycles(4);
        check("7e1_bad_count", strobes - s0, 2);
        check("7e1_bad_rbr", rbr_out, 8'h35);
        check("7e1_bad_pe", pe_out, 1'b1);
        check("7e1_bad_fe", fe_out, 1'b0);

        // 16x 5-bit stick parity (expected parity bit 0).
        osm_sel_in = 1'b0; wls_in = 2'd0; pen_in = 1'b1; eps_in = 1'b1; sp_in = 1'b1;
        send_char(8'h1F, 5, 1'b1, 1'b1, 1'b1, 16);
        cycles(4);
        check("stick_p1_pe", pe_out, 1'b1);
        send_char(8'h1F, 5, 1'b1, 1'b0, 1'b1, 16);
        cycles(4);
        check("stick_p0_pe", pe_out, 1'b0);
        check("stick_p0_rbr", rbr_out, 8'h1F);

        // Back to 8N1; short low glitch on an idle line.
        wls_in = 2'd3; pen_in = 1'b0; eps_in = 1'b0; sp_in = 1'b0;
        s0 = strobes;
        drive_bit(1'b0, 4);
        serial_in = 1'b1;
        check("glitch_busy_hi", busy_out, 1'b1);
        cycles(8);
        check("glitch_busy_lo", busy_out, 1'b0);
        cycles(20);
        check("glitch_count", strobes - s0, 0);

        // Break: line low for three frame times.
        s0 = strobes;
        drive_bit(1'b0, 480);
        check("brk_count", strobes - s0, 1);
        check("brk_rbr", rbr_out, 8'h00);
        check("brk_fe_bi", {fe_out, bi_out}, 2'b11);
        check("brk_wait_busy", busy_out, 1'b1);
        drive_bit(1'b1, 8);
        check("brk_idle_busy", busy_out, 1'b0);
        send_char(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        cycles(4);
        check("post_brk_count", strobes - s0, 2);
        check("post_brk_rbr", rbr_out, 8'h5A);
        check("post_brk_fe_bi", {fe_out, bi_out}, 2'b00);

        // Drop enable during data bit 3.
        s0 = strobes;
        fork
            send_char(8'h96, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                cycles(56);
                enable_in = 1'b0;
                cycles(2);
                check("en_abort_busy", busy_out, 1'b0);
            end
        join
        cycles(4);
        enable_in = 1'b1;
        cycles(4);
        check("en_abort_count", strobes - s0, 0);
        check("en_abort_rbr_held", rbr_out, 8'h5A);

        // Reset pulse during data bit 3 of an all-ones character.
        s0 = strobes;
        fork
            send_char(8'hFF, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                cycles(56);
                check("rst_abort_busy_pre", busy_out, 1'b1);
                #2;
                rstn_in = 1'b0;
                #1;
                check("rst_abort_rbr", rbr_out, 8'h00);
                check("rst_abort_flags", {rx_valid_out, pe_out, fe_out, bi_out, busy_out}, 5'b0);
                cycles(2);
                rstn_in = 1'b1;
                cycles(1);
                check("rst_abort_busy_post", busy_out, 1'b0);
            end
        join
        cycles(4);
        check("rst_abort_count", strobes - s0, 0);

        // 0xC3 with configuration inputs disturbed mid-frame.
        s0 = strobes;
        fork
            send_char(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                cycles(40);
                wls_in = 2'd0; pen_in = 1'b1; osm_sel_in = 1'b1;
            end
        join
        cycles(4);
        check("c3_count", strobes - s0, 1);
        check("c3_rbr", rbr_out, 8'hC3);
        check("c3_flags", {pe_out, fe_out, bi_out}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive deserializer and the receive-direction counterpart of the transmit shifter.
- Oversamples serial_in on bclk_in at 16x or 13x and detects and validates the start bit.
- Samples 5–8 data bits LSB-first, then the optional parity bit and the stop bit.
- Presents the received character with parity, framing and break status as a one-cycle strobe to the RBR/FIFO logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial_in metastability synchronizer (minimum 2).

Ports:
- bclk_in  input  1  oversample clock (16x or 13x baud).
- rstn_in  input  1  reset: asynchronous, active-low.
- enable_in  input  1  receiver enable; low forces IDLE.
- serial_in  input  1  asynchronous RX line, idle high.
- osm_sel_in  input  1  1 = 13x oversample, 0 = 16x.
- wls_in  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits.
- pen_in  input  1  parity enable.
- eps_in  input  1  even parity select (1 = even).
- sp_in  input  1  stick parity; expected parity bit = !eps_in.
- rbr_out  output  8  received character, right-justified, unused MSBs 0.
- rx_valid_out  output  1  one-cycle strobe; rbr_out and status are valid.
- pe_out  output  1  parity error for this character.
- fe_out  output  1  framing error (stop bit sampled 0).
- bi_out  output  1  break: data, parity and stop bits all 0.
- busy_out  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, counters 0.
  - Synchronizer flops 1.
- Bit timing:
  - rxd is serial_in after SYNC_STAGES flops.
  - N = 13 if osm_sel_in else 16; HALF = 6 if 13x else 7.
  - cyc counter counts 0..N-1.
- Configuration latch: on the IDLE->START transition, latch osm_sel_in, wls_in, pen_in, eps_in and sp_in. Mid-frame changes do not affect the current frame.
- State machine:
  - IDLE: on rxd==0 with enable_in=1, set cyc=0 and go to START.
  - START: when cyc==HALF, sample rxd.
    - rxd==1: false start, return to IDLE, no strobe.
    - rxd==0: set cyc=0, bitcnt=0, go to DATA.
  - DATA: when cyc==N-1, sample rxd into shift[bitcnt] (LSB first) and set cyc=0.
    - After bit (wls+4) is sampled, go to PARITY if pen is set, else STOP.
  - PARITY: when cyc==N-1, sample the parity bit and go to STOP. Expected parity:
    - sp=1: expected = !eps.
    - sp=0, eps=1: expected = XOR of the data bits (even parity).
    - sp=0, eps=0: expected = the inverse of that XOR (odd parity).
    - pe = (sampled != expected).
  - STOP: when cyc==N-1, sample the stop bit, then on the same edge:
    - Load rbr_out and set pe_out, fe_out = !stop and bi_out = (all data bits 0, parity 0 or absent, stop 0).
    - Pulse rx_valid_out for exactly 1 cycle.
    - Go to IDLE if stop==1, else to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd==1, then go to IDLE. This prevents a break from being re-detected as a start bit.
  - Only the first stop bit is checked; stb has no receive effect.
- Status holding: pe_out, fe_out and bi_out hold until the next rx_valid_out. They are cleared only by reset.
- enable_in deasserted in any state: next state is IDLE, no strobe, partial data discarded.
- Reset mid-frame: immediate asynchronous return to reset values; no strobe.
- Timing: the data sample point is 8 + k*16 cycles (16x) after start detection, centred in each bit cell.

Decomposition:
- Shared package uart_pkg:
  - Receive state encodings: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - OSM_16 = 16, OSM_13 = 13, HALF_16 = 7, HALF_13 = 6.
  - WLS to bit-count function.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop synchronizer with reset value 1.

Test Plan:
- 16x, 8N1 (wls=3, pen=0), byte 0xA5 at 16 bclk/bit: one rx_valid_out about 152 (±3) cycles after the falling edge, rbr_out=0xA5, pe=fe=bi=0.
- 13x, 7E1 (wls=2, pen=1, eps=1, sp=0), data 0x35 with correct parity bit 0: rbr_out=0x35, pe=0. Repeat with parity bit 1: pe_out=1, data still 0x35.
- 5-bit stick parity (wls=0, pen=1, sp=1, eps=1), data 0x1F with parity bit 1: pe_out=1. Repeat with parity 0: pe_out=0, rbr_out=0x1F (bits 7:5 = 0).
- Glitch: 4-cycle low pulse on idle line: no rx_valid_out, busy_out returns 0 within 8 cycles. Break: line held low for 3 frames: exactly one strobe with rbr=0x00, fe=1, bi=1, no further strobes until the line goes high, then 0x5A is received correctly.
- Mid-frame abort: drop enable_in during bit 3, or pulse rstn_in low: no strobe, busy_out=0, all outputs back to reset values after rstn_in. The next frame 0xC3 is received correctly.
